press_relax_controller: RTL and testbench

//  Sequencing controller in front of the press/relax counting datapath. Takes the raw
//  DE10-Lite KEY input, synchronises and debounces it, and classifies each press as short
//  or long. Emits one-cycle increment strobes for the press and relax counters, and a

---
 rtl/press_relax_controller.sv | 127 ++++++++++++
 tb/tb_press_relax_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/press_relax_controller.sv
// Push-button front end for the press/relax counters: synchronises and debounces the
// raw KEY level, classifies presses as short or long and emits counter control strobes.
module press_relax_controller #(
  parameter bit BUTTON_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_CYCLES   = 500_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       button_i,
  output logic       press_inc_o,
  output logic       relax_inc_o,
  output logic       clear_o,
  output logic       long_press_o,
  output logic [2:0] state_o
);

  localparam int TW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_PRESS_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX = '1;
  localparam logic          RELEASED  = BUTTON_ACTIVE_LOW;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DEB = 3'd1,
    PRESSED   = 3'd2,
    LONG_HELD = 3'd3,
    RELAX_DEB = 3'd4
  } state_e;

  state_e        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          long_flag;
  logic [1:0]    sync;
  logic          lvl;

  // Reset to the released level so a reset never looks like a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync <= {2{RELEASED}};
    else       sync <= {sync[0], button_i};
  end

  assign lvl        = sync[1] ^ RELEASED;
  assign timer_next = (timer == TIMER_MAX) ? timer : timer + TW'(1);
  assign state_o    = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      timer        <= '0;
      long_flag    <= 1'b0;
      press_inc_o  <= 1'b0;
      relax_inc_o  <= 1'b0;
      clear_o      <= 1'b0;
      long_press_o <= 1'b0;
    end else begin
      press_inc_o <= 1'b0;
      relax_inc_o <= 1'b0;
      clear_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (lvl) begin
            state <= PRESS_DEB;
            timer <= '0;
          end
        end
        PRESS_DEB: begin
          if (!lvl) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == DEB_LAST) begin
            state       <= PRESSED;
            timer       <= '0;
            long_flag   <= 1'b0;
            press_inc_o <= 1'b1;
          end else begin
            timer <= timer_next;
          end
        end
        PRESSED: begin
          if (!lvl) begin
            state <= RELAX_DEB;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state        <= LONG_HELD;
            timer        <= '0;
            long_flag    <= 1'b1;
            clear_o      <= 1'b1;
            long_press_o <= 1'b1;
          end else begin
            timer <= timer_next;
          end
        end
        LONG_HELD: begin
          if (!lvl) begin
            state <= RELAX_DEB;
            timer <= '0;
          end
        end
        RELAX_DEB: begin
          // A bounce returns to the held state with a fresh long-press window.
          if (lvl) begin
            state <= long_flag ? LONG_HELD : PRESSED;
            timer <= '0;
          end else if (timer == DEB_LAST) begin
            state        <= IDLE;
            timer        <= '0;
            long_flag    <= 1'b0;
            long_press_o <= 1'b0;
            relax_inc_o  <= ~long_flag;
          end else begin
            timer <= timer_next;
          end
        end
        default: begin
          state        <= IDLE;
          timer        <= '0;
          long_flag    <= 1'b0;
          long_press_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_relax_controller.sv
// Scoreboard bench for press_relax_controller: a run-length reference model predicts
// strobe/level events per cycle; a negedge monitor pops and compares what the DUT shows.
module tb_press_relax_controller;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  localparam int EV_PRESS = 0;
  localparam int EV_RELAX = 1;
  localparam int EV_CLEAR = 2;
  localparam int EV_LON   = 3;
  localparam int EV_LOFF  = 4;

  typedef struct {
    int kind;
    int tag;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       button = 1'b1;
  logic       press_inc, relax_inc, clear, long_press;
  logic [2:0] state;

  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  ev_t  sb[$];
  logic prev_long = 1'b0;
  int   cnt_press = 0, cnt_relax = 0, cnt_clear = 0;

  // reference model: accepted level plus run lengths of the synchronised samples
  bit m_held, m_long;
  int m_run_on, m_run_off, m_hold_run;

  press_relax_controller #(
    .BUTTON_ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .button_i    (button),
    .press_inc_o (press_inc),
    .relax_inc_o (relax_inc),
    .clear_o     (clear),
    .long_press_o(long_press),
    .state_o     (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int tag);
    ev_t e;
    e.kind = kind;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_held = 0; m_long = 0; m_run_on = 0; m_run_off = 0; m_hold_run = 0;
  endtask

  // s: button pressed at the sample the DUT FSM will act on at edge 'tag'
  task automatic model_step(input bit s, input int tag);
    if (!m_held) begin
      m_run_on = s ? m_run_on + 1 : 0;
      if (m_run_on == DEB + 1) begin
        push(EV_PRESS, tag);
        m_held = 1; m_long = 0; m_hold_run = 1; m_run_off = 0;
      end
    end else if (s) begin
      m_run_off = 0;
      m_hold_run++;
      if (!m_long && m_hold_run == LONG + 1) begin
        push(EV_CLEAR, tag);
        push(EV_LON, tag);
        m_long = 1;
      end
    end else begin
      m_hold_run = 0;
      m_run_off++;
      if (m_run_off == DEB + 1) begin
        push(m_long ? EV_LOFF : EV_RELAX, tag);
        m_held = 0; m_long = 0; m_run_on = 0;
      end
    end
  endtask

  // Synchroniser adds two edges; the sample is acted on at the third edge from now.
  task automatic drive(input bit pressed, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      button = pressed ? 1'b0 : 1'b1;
      model_step(pressed, edge_cnt + 3);
    end
  endtask

  task automatic expect_ev(input int kind);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d cycle=%0d expected=none", kind, edge_cnt);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.tag != edge_cnt) begin
        failures++;
        $display("FAIL event_match actual kind=%0d cycle=%0d expected kind=%0d cycle=%0d",
                 kind, edge_cnt, e.kind, e.tag);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_long = 1'b0;
    end else begin
      while (sb.size() > 0 && sb[0].tag < edge_cnt) begin
        checks++;
        failures++;
        $display("FAIL missed_event actual=absent expected kind=%0d cycle=%0d",
                 sb[0].kind, sb[0].tag);
        void'(sb.pop_front());
      end
      if (press_inc || relax_inc || clear)
        check("strobe_exclusive", int'(press_inc) + int'(relax_inc) + int'(clear), 1);
      if (press_inc) begin cnt_press++; expect_ev(EV_PRESS); end
      if (relax_inc) begin cnt_relax++; expect_ev(EV_RELAX); end
      if (clear)     begin cnt_clear++; expect_ev(EV_CLEAR); end
      if (long_press && !prev_long) expect_ev(EV_LON);
      if (!long_press && prev_long) expect_ev(EV_LOFF);
      prev_long = long_press;
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_counts(input string name, input int p0, input int r0, input int c0,
                              input int p, input int r, input int c);
    check({name, "_press"}, cnt_press - p0, p);
    check({name, "_relax"}, cnt_relax - r0, r);
    check({name, "_clear"}, cnt_clear - c0, c);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_outs"}, int'({press_inc, relax_inc, clear, long_press, state}), 0);
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_quiet(name);
    sb.delete();
    model_reset();
    @(negedge clk);
    button = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int p0, r0, c0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_quiet("reset_initial");
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // clean short press
    p0 = cnt_press; r0 = cnt_relax; c0 = cnt_clear;
    drive(1, 10); drive(0, 12); settle();
    check_counts("short", p0, r0, c0, 1, 1, 0);
    check_quiet("short_idle");

    // glitch shorter than the debounce window
    p0 = cnt_press; r0 = cnt_relax; c0 = cnt_clear;
    drive(1, 3); drive(0, 10); settle();
    check_counts("glitch", p0, r0, c0, 0, 0, 0);
    check_quiet("glitch_idle");

    // bouncy release
    p0 = cnt_press; r0 = cnt_relax; c0 = cnt_clear;
    drive(1, 10);
    repeat (3) begin drive(0, 2); drive(1, 2); end
    drive(0, 12); settle();
    check_counts("bounce", p0, r0, c0, 1, 1, 0);

    // long press: clear once, release not counted
    p0 = cnt_press; r0 = cnt_relax; c0 = cnt_clear;
    drive(1, 40); settle();
    check("long_level", long_press, 1);
    check("long_state", state, 3);
    drive(0, 12); settle();
    check_counts("long", p0, r0, c0, 1, 0, 1);
    check_quiet("long_idle");

    // back-to-back short presses
    p0 = cnt_press; r0 = cnt_relax; c0 = cnt_clear;
    repeat (5) begin drive(1, 8); drive(0, 8); end
    drive(0, 6); settle();
    check_counts("b2b", p0, r0, c0, 5, 5, 0);

    // asynchronous reset while PRESSED, then while LONG_HELD
    drive(1, 12); settle();
    check("pressed_state", state, 2);
    async_reset("reset_pressed");
    drive(1, 30); settle();
    check("long_state_pre_reset", state, 3);
    async_reset("reset_long");
    p0 = cnt_press;
    drive(0, 10); settle();
    check("post_reset_no_press", cnt_press - p0, 0);

    // randomized button waveform
    for (int i = 0; i < 60; i++) begin
      drive(bit'($urandom_range(0, 1)), $urandom_range(1, 26));
    end
    drive(0, 30); settle();
    check("sb_drained", sb.size(), 0);
    check_quiet("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
